// File: rtl/wait_event_engine.sv
// rtl/wait_event_engine.sv - single-channel event waiter with timeout, abort and elapsed-cycle report
//
// Purpose:
//   On start, latches a channel select, event mode, compare value and timeout.
//   It then watches the selected channel of wait_signals until the event occurs,
//   the timeout expires, or abort is given.
//
// Ports:
//   clk, rst_n     - clock and asynchronous active-low reset
//   start          - request a wait (sampled only in IDLE)
//   abort          - cancel the wait in progress
//   sel            - channel index to monitor
//   mode           - 00 rising bit0, 01 falling bit0, 10 level equal, 11 any change
//   match_value    - compare value for level mode
//   max_timeout    - timeout in cycles, 0 disables it
//   wait_signals   - flattened channels, channel i at [i*WAIT_WIDTH +: WAIT_WIDTH]
//   busy           - high while waiting
//   done           - one-cycle pulse on event
//   timeout        - one-cycle pulse on expiry
//   err            - one-cycle pulse on start with an out-of-range sel
//   elapsed        - WAIT cycles used by the last completed wait
module wait_event_engine #(
    parameter int WAIT_SIZE     = 5,
    parameter int WAIT_WIDTH    = 1,
    parameter int TIMEOUT_WIDTH = 32,
    parameter int SEL_WIDTH     = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            abort,
    input  logic [SEL_WIDTH-1:0]            sel,
    input  logic [1:0]                      mode,
    input  logic [WAIT_WIDTH-1:0]           match_value,
    input  logic [TIMEOUT_WIDTH-1:0]        max_timeout,
    input  logic [WAIT_SIZE*WAIT_WIDTH-1:0] wait_signals,
    output logic                            busy,
    output logic                            done,
    output logic                            timeout,
    output logic                            err,
    output logic [TIMEOUT_WIDTH-1:0]        elapsed
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [TIMEOUT_WIDTH-1:0] CNT_MAX = '1;

    logic [0:0]               state_q, state_d;
    logic [SEL_WIDTH-1:0]     sel_q, sel_d;
    logic [1:0]               mode_q, mode_d;
    logic [WAIT_WIDTH-1:0]    match_q, match_d;
    logic [TIMEOUT_WIDTH-1:0] max_to_q, max_to_d;
    logic [WAIT_WIDTH-1:0]    prev_q, prev_d;
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
    logic [TIMEOUT_WIDTH-1:0] elapsed_q, elapsed_d;
    logic                     done_q, done_d;
    logic                     timeout_q, timeout_d;
    logic                     err_q, err_d;

    // live_chan follows the sel input (used when a wait is accepted);
    // cur_chan follows the latched select (used while waiting).
    logic [WAIT_WIDTH-1:0]    live_chan;
    logic [WAIT_WIDTH-1:0]    cur_chan;
    logic                     sel_valid;

    always_comb begin
        live_chan = '0;
        cur_chan  = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < WAIT_SIZE; i++) begin
            if (sel == SEL_WIDTH'(i)) begin
                live_chan = wait_signals[i*WAIT_WIDTH +: WAIT_WIDTH];
                sel_valid = 1'b1;
            end
            if (sel_q == SEL_WIDTH'(i)) begin
                cur_chan = wait_signals[i*WAIT_WIDTH +: WAIT_WIDTH];
            end
        end
    end

    logic event_hit;

    always_comb begin
        event_hit = 1'b0;
        case (mode_q)
            2'b00:   event_hit = !prev_q[0] && cur_chan[0];
            2'b01:   event_hit = prev_q[0] && !cur_chan[0];
            2'b10:   event_hit = (cur_chan == match_q);
            default: event_hit = (cur_chan != prev_q);
        endcase
    end

    // Saturating increment keeps an untimed wait from wrapping back to zero.
    logic [TIMEOUT_WIDTH-1:0] cnt_next;
    logic                     expire;

    assign cnt_next = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + TIMEOUT_WIDTH'(1);
    assign expire   = (max_to_q != '0) && (cnt_next == max_to_q);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        mode_d    = mode_q;
        match_d   = match_q;
        max_to_d  = max_to_q;
        prev_d    = prev_q;
        cnt_d     = cnt_q;
        elapsed_d = elapsed_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (sel_valid) begin
                        sel_d    = sel;
                        mode_d   = mode;
                        match_d  = match_value;
                        max_to_d = max_timeout;
                        prev_d   = live_chan;
                        cnt_d    = '0;
                        state_d  = ST_WAIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                prev_d = cur_chan;
                // Priority: abort, then event, then expiry.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (event_hit) begin
                    done_d    = 1'b1;
                    elapsed_d = cnt_next;
                    state_d   = ST_IDLE;
                end else if (expire) begin
                    timeout_d = 1'b1;
                    elapsed_d = max_to_q;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_next;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            mode_q    <= '0;
            match_q   <= '0;
            max_to_q  <= '0;
            prev_q    <= '0;
            cnt_q     <= '0;
            elapsed_q <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            mode_q    <= mode_d;
            match_q   <= match_d;
            max_to_q  <= max_to_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            elapsed_q <= elapsed_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
        end
    end

    assign busy    = (state_q == ST_WAIT);
    assign done    = done_q;
    assign timeout = timeout_q;
    assign err     = err_q;
    assign elapsed = elapsed_q;

endmodule

// File: tb/tb_wait_event_engine.sv
// tb/tb_wait_event_engine.sv - self-checking bench for wait_event_engine
module tb_wait_event_engine;

    localparam int WS = 5;
    localparam int WW = 8;
    localparam int TW = 32;
    localparam int SW = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [SW-1:0]     sel;
    logic [1:0]        mode;
    logic [WW-1:0]     match_value;
    logic [TW-1:0]     max_timeout;
    logic [WS*WW-1:0]  wait_signals;
    logic              busy;
    logic              done;
    logic              timeout;
    logic              err;
    logic [TW-1:0]     elapsed;

    wait_event_engine #(
        .WAIT_SIZE    (WS),
        .WAIT_WIDTH   (WW),
        .TIMEOUT_WIDTH(TW),
        .SEL_WIDTH    (SW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .sel         (sel),
        .mode        (mode),
        .match_value (match_value),
        .max_timeout (max_timeout),
        .wait_signals(wait_signals),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .err         (err),
        .elapsed     (elapsed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          d;
        logic          t;
        logic          e;
        logic [TW-1:0] el;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   edges = 0;
    int   start_edge = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edges++;
        #1;
    endtask

    task automatic set_chan(input int ch, input logic [WW-1:0] v);
        wait_signals[ch*WW +: WW] = v;
    endtask

    task automatic push_exp(input logic d, input logic t, input logic e,
                            input logic [TW-1:0] el, input int lat);
        exp_t x;
        x.d = d; x.t = t; x.e = e; x.el = el; x.lat = lat;
        sb.push_back(x);
    endtask

    task automatic do_start(input logic [SW-1:0] s, input logic [1:0] m,
                            input logic [WW-1:0] mv, input logic [TW-1:0] to,
                            input bit keep);
        sel = s; mode = m; match_value = mv; max_timeout = to;
        start = 1'b1;
        tick();
        start_edge = edges;
        if (!keep) start = 1'b0;
    endtask

    // Waits (bounded) for the next pulse, pops the expected result and compares.
    task automatic wait_result(input string tag, input int budget);
        exp_t x;
        int   n = 0;
        while (!(done | timeout | err) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_pulse_seen"}, 64'(done | timeout | err), 64'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 64'd0, 64'd1);
            return;
        end
        x = sb.pop_front();
        if (!(done | timeout | err)) return;
        check({tag, "_done"},    64'(done),    64'(x.d));
        check({tag, "_timeout"}, 64'(timeout), 64'(x.t));
        check({tag, "_err"},     64'(err),     64'(x.e));
        check({tag, "_elapsed"}, 64'(elapsed), 64'(x.el));
        check({tag, "_latency"}, 64'(edges - start_edge), 64'(x.lat));
        check({tag, "_busy_at_pulse"}, 64'(busy), 64'd0);
        start = 1'b0;
        tick();
        check({tag, "_pulse_one_cycle"}, 64'({done, timeout, err}), 64'd0);
        check({tag, "_idle_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; sel = '0; mode = '0;
        match_value = '0; max_timeout = '0; wait_signals = '0;
        tick(); tick();
        check("reset_outputs", 64'({busy, done, timeout, err}), 64'd0);
        check("reset_elapsed", 64'(elapsed), 64'd0);
        rst_n = 1'b1;

        // Rising on channel 2, channel goes high before the 4th WAIT edge.
        push_exp(1'b1, 1'b0, 1'b0, 32'd4, 4);
        do_start(3'd2, 2'b00, 8'h00, 32'd100, 1'b0);
        check("rise_busy", 64'(busy), 64'd1);
        tick(); tick(); tick();
        set_chan(2, 8'h01);
        wait_result("rise", 20);

        // Level equal, already matching at start.
        set_chan(1, 8'h72);
        push_exp(1'b1, 1'b0, 1'b0, 32'd1, 1);
        do_start(3'd1, 2'b10, 8'h72, 32'd0, 1'b0);
        wait_result("level_now", 20);

        // Falling never happens -> timeout after 3 edges.
        push_exp(1'b0, 1'b1, 1'b0, 32'd3, 3);
        do_start(3'd0, 2'b01, 8'h00, 32'd3, 1'b0);
        wait_result("fall_timeout", 20);

        // Event on the same edge as expiry: done wins.
        push_exp(1'b1, 1'b0, 1'b0, 32'd5, 5);
        do_start(3'd3, 2'b00, 8'h00, 32'd5, 1'b0);
        tick(); tick(); tick(); tick();
        set_chan(3, 8'h01);
        wait_result("collide", 20);

        // Abort on the second WAIT edge: no pulse, elapsed kept.
        do_start(3'd0, 2'b00, 8'h00, 32'd0, 1'b0);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_no_pulse", 64'({done, timeout, err}), 64'd0);
        check("abort_elapsed", 64'(elapsed), 64'd5);
        tick();
        check("abort_quiet", 64'({busy, done, timeout, err}), 64'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle_noeffect", 64'({busy, done, timeout, err}), 64'd0);

        // Illegal select.
        push_exp(1'b0, 1'b0, 1'b1, 32'd5, 0);
        do_start(3'd6, 2'b00, 8'h00, 32'd0, 1'b0);
        wait_result("bad_sel", 5);

        // Any change on the upper bit of an 8-bit channel.
        push_exp(1'b1, 1'b0, 1'b0, 32'd3, 3);
        do_start(3'd4, 2'b11, 8'h00, 32'd0, 1'b0);
        tick(); tick();
        set_chan(4, 8'h80);
        wait_result("change", 20);

        // Configuration inputs changed mid-wait must not matter.
        set_chan(1, 8'h00);
        push_exp(1'b1, 1'b0, 1'b0, 32'd4, 4);
        do_start(3'd1, 2'b10, 8'h55, 32'd0, 1'b0);
        sel = 3'd0; match_value = 8'h00; mode = 2'b00; max_timeout = 32'd1;
        tick(); tick(); tick();
        set_chan(1, 8'h55);
        wait_result("latched_cfg", 20);

        // Shortest timeout.
        push_exp(1'b0, 1'b1, 1'b0, 32'd1, 1);
        do_start(3'd0, 2'b00, 8'h00, 32'd1, 1'b0);
        wait_result("timeout_one", 10);

        // start held high for the whole wait and on the return edge.
        push_exp(1'b0, 1'b1, 1'b0, 32'd4, 4);
        do_start(3'd0, 2'b00, 8'h00, 32'd4, 1'b1);
        wait_result("start_held", 20);

        // Reset in the middle of a wait.
        do_start(3'd0, 2'b00, 8'h00, 32'd0, 1'b0);
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", 64'({busy, done, timeout, err}), 64'd0);
        check("rst_mid_elapsed", 64'(elapsed), 64'd0);
        set_chan(0, 8'h01);
        tick(); tick();
        rst_n = 1'b1;
        push_exp(1'b1, 1'b0, 1'b0, 32'd1, 1);
        do_start(3'd1, 2'b10, 8'h55, 32'd0, 1'b0);
        check("rst_first_start_busy", 64'(busy), 64'd1);
        wait_result("after_reset", 20);
        tick(); tick();
        check("final_quiet", 64'({busy, done, timeout, err}), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
